icap_multiboot: RTL and testbench

Parametrised Spartan-6 MultiBoot sequencer: on a request carrying an image index, it computes that image's SPI flash address. It then streams the full ICAP command sequence (sync, GENERAL_1..4, REBOOT, NOOPs) onto registered, byte-bit-reversed ICAP pins. It sits between the host-visible control register (image select) and an externally instantiated ICAP_SPARTAN6, which lets the bench observe the stream. It adds runtime image selection, a golden fallback address, a request/busy/error handshake and a parametrised power-up holdoff.

---
 rtl/icap_multiboot.sv | 190 +++++++++++++++++++
 tb/tb_icap_multiboot.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_multiboot.sv
// Spartan-6 MultiBoot sequencer: selects a flash image by index and
// streams the ICAP reboot command sequence onto registered pins.
module icap_multiboot #(
   parameter int          NUM_IMAGES      = 8,
   parameter int          IDX_W           = 4,
   parameter logic [23:0] IMAGE_BASE      = 24'h054000,
   parameter logic [23:0] IMAGE_STRIDE    = 24'h054000,
   parameter logic [7:0]  SPI_READ_CMD    = 8'h03,
   parameter bit          ENABLE_FALLBACK = 1'b1,
   parameter logic [23:0] FALLBACK_ADDR   = 24'h000000,
   parameter int          STARTUP_DELAY   = 15
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             err_o,
   output logic             issued_o,
   output logic             icap_ce_n_o,
   output logic             icap_wr_n_o,
   output logic [15:0]      icap_i_o
);

   typedef enum logic [2:0] {
      HOLDOFF,
      IDLE,
      LOAD,
      SEND,
      DONE
   } state_t;

   localparam logic [4:0] N_WORDS =
      (ENABLE_FALLBACK != 1'b0) ? 5'd16 : 5'd12;

   localparam logic [15:0] HOLD_LAST = 16'(STARTUP_DELAY - 1);

   // Extra top bit so NUM_IMAGES == 2**IDX_W still compares correctly.
   localparam logic [IDX_W:0] NUM_LIM = (IDX_W + 1)'(NUM_IMAGES);

   state_t           state_q;
   logic [15:0]      hold_q;
   logic [4:0]       k_q;
   logic [IDX_W-1:0] idx_q;
   logic [23:0]      addr_q;
   logic             ready_q;
   logic             busy_q;
   logic             err_q;
   logic             issued_q;
   logic             ce_n_q;
   logic             wr_n_q;
   logic [15:0]      icap_q;

   logic [15:0]      word_d;
   logic [15:0]      gen1;
   logic [15:0]      gen2;
   logic [15:0]      gen3;
   logic [15:0]      gen4;
   logic             idx_ok;

   // ICAP expects each byte presented MSB-first on the D0 side.
   function automatic logic [15:0] swap_bits(input logic [15:0] w);
      logic [15:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         r[7-j]  = w[j];
         r[15-j] = w[8+j];
      end
      return r;
   endfunction

   assign idx_ok = ({1'b0, idx_i} < NUM_LIM);

   assign gen1 = addr_q[15:0];
   assign gen2 = {SPI_READ_CMD, addr_q[23:16]};
   assign gen3 = FALLBACK_ADDR[15:0];
   assign gen4 = {SPI_READ_CMD, FALLBACK_ADDR[23:16]};

   // Select the command word for the current stream position.
   always_comb begin
      word_d = 16'h2000;
      if (ENABLE_FALLBACK != 1'b0) begin
         case (k_q)
            5'd0:    word_d = 16'hAA99;
            5'd1:    word_d = 16'h5566;
            5'd2:    word_d = 16'h3261;
            5'd3:    word_d = gen1;
            5'd4:    word_d = 16'h3281;
            5'd5:    word_d = gen2;
            5'd6:    word_d = 16'h32A1;
            5'd7:    word_d = gen3;
            5'd8:    word_d = 16'h32C1;
            5'd9:    word_d = gen4;
            5'd10:   word_d = 16'h30A1;
            5'd11:   word_d = 16'h000E;
            default: word_d = 16'h2000;
         endcase
      end else begin
         case (k_q)
            5'd0:    word_d = 16'hAA99;
            5'd1:    word_d = 16'h5566;
            5'd2:    word_d = 16'h3261;
            5'd3:    word_d = gen1;
            5'd4:    word_d = 16'h3281;
            5'd5:    word_d = gen2;
            5'd6:    word_d = 16'h30A1;
            5'd7:    word_d = 16'h000E;
            default: word_d = 16'h2000;
         endcase
      end
   end

   // Sequencer FSM with all handshake and ICAP pins registered.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= HOLDOFF;
         hold_q   <= '0;
         k_q      <= '0;
         idx_q    <= '0;
         addr_q   <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         issued_q <= 1'b0;
         ce_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         icap_q   <= 16'hFFFF;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            HOLDOFF: begin
               if (hold_q == HOLD_LAST) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  hold_q <= hold_q + 16'd1;
               end
            end
            IDLE: begin
               if (req_i) begin
                  if (idx_ok) begin
                     idx_q   <= idx_i;
                     state_q <= LOAD;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // Address wraps modulo 2**24 by truncation.
               addr_q  <= IMAGE_BASE + (24'(idx_q) * IMAGE_STRIDE);
               k_q     <= '0;
               state_q <= SEND;
            end
            SEND: begin
               if (k_q == N_WORDS) begin
                  ce_n_q   <= 1'b1;
                  wr_n_q   <= 1'b1;
                  icap_q   <= 16'hFFFF;
                  issued_q <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  ce_n_q <= 1'b0;
                  wr_n_q <= 1'b0;
                  icap_q <= swap_bits(word_d);
                  k_q    <= k_q + 5'd1;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= HOLDOFF;
            end
         endcase
      end
   end

   assign ready_o     = ready_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;
   assign issued_o    = issued_q;
   assign icap_ce_n_o = ce_n_q;
   assign icap_wr_n_o = wr_n_q;
   assign icap_i_o    = icap_q;

endmodule

// File: tb/tb_icap_multiboot.sv
// Bench for icap_multiboot: three parameterisations checked against
// a word-list model of the MultiBoot command stream.
module tb_icap_multiboot;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [2:0]      req;
   logic [2:0][3:0] idx;

   wire [2:0]       ready;
   wire [2:0]       busy;
   wire [2:0]       err;
   wire [2:0]       issued;
   wire [2:0]       ce_n;
   wire [2:0]       wr_n;
   wire [2:0][15:0] icap;

   int checks = 0;
   int errors = 0;

   int unsigned m_base[3]   = '{32'h054000, 32'h054000, 32'hFF0000};
   int unsigned m_stride[3] = '{32'h054000, 32'h054000, 32'h020000};
   bit          m_fb[3]     = '{1'b1, 1'b0, 1'b1};

   logic [15:0] expq[$];
   logic [15:0] got[$];

   icap_multiboot u0 (
      .clk_i(clk), .reset_i(rst), .req_i(req[0]), .idx_i(idx[0]),
      .ready_o(ready[0]), .busy_o(busy[0]), .err_o(err[0]),
      .issued_o(issued[0]), .icap_ce_n_o(ce_n[0]),
      .icap_wr_n_o(wr_n[0]), .icap_i_o(icap[0])
   );

   icap_multiboot #(.ENABLE_FALLBACK(1'b0)) u1 (
      .clk_i(clk), .reset_i(rst), .req_i(req[1]), .idx_i(idx[1]),
      .ready_o(ready[1]), .busy_o(busy[1]), .err_o(err[1]),
      .issued_o(issued[1]), .icap_ce_n_o(ce_n[1]),
      .icap_wr_n_o(wr_n[1]), .icap_i_o(icap[1])
   );

   icap_multiboot #(
      .IMAGE_BASE(24'hFF0000), .IMAGE_STRIDE(24'h020000)
   ) u2 (
      .clk_i(clk), .reset_i(rst), .req_i(req[2]), .idx_i(idx[2]),
      .ready_o(ready[2]), .busy_o(busy[2]), .err_o(err[2]),
      .issued_o(issued[2]), .icap_ce_n_o(ce_n[2]),
      .icap_wr_n_o(wr_n[2]), .icap_i_o(icap[2])
   );

   function automatic logic [15:0] rev(input logic [15:0] w);
      logic [7:0] lo, hi, rl, rh;
      lo = w[7:0];
      hi = w[15:8];
      rl = {<<{lo}};
      rh = {<<{hi}};
      return {rh, rl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic build_exp(input int d, input int ix);
      longint      a;
      logic [23:0] ad;
      a  = longint'(m_base[d]) + longint'(ix) * longint'(m_stride[d]);
      ad = a[23:0];
      expq.delete();
      expq.push_back(16'hAA99);
      expq.push_back(16'h5566);
      expq.push_back(16'h3261);
      expq.push_back(ad[15:0]);
      expq.push_back(16'h3281);
      expq.push_back({8'h03, ad[23:16]});
      if (m_fb[d]) begin
         expq.push_back(16'h32A1);
         expq.push_back(16'h0000);
         expq.push_back(16'h32C1);
         expq.push_back(16'h0300);
      end
      expq.push_back(16'h30A1);
      expq.push_back(16'h000E);
      repeat (4) expq.push_back(16'h2000);
   endtask

   task automatic wait_ready(input int d, output int n);
      n = 0;
      while (ready[d] !== 1'b1 && n < 200) begin
         tick;
         n++;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic do_req(input int d, input int ix, input bit hold2,
                         input int abort_k);
      int n;
      wait_ready(d, n);
      chk("ready_before_req", ready[d], 1);
      build_exp(d, ix);
      req[d] = 1'b1;
      idx[d] = 4'(ix);
      tick;
      if (ix >= 8) begin
         req[d] = 1'b0;
         chk("err_pulse", err[d], 1);
         chk("err_ready", ready[d], 1);
         chk("err_busy", busy[d], 0);
         chk("err_ce_n", ce_n[d], 1);
         tick;
         chk("err_clear", err[d], 0);
         chk("err_ready2", ready[d], 1);
         chk("err_ce_n2", ce_n[d], 1);
         return;
      end
      chk("acc_busy", busy[d], 1);
      chk("acc_ready", ready[d], 0);
      chk("acc_err", err[d], 0);
      if (hold2) idx[d] = 4'((ix + 1) % 8);
      else req[d] = 1'b0;
      tick;
      req[d] = 1'b0;
      chk("load_idle", ce_n[d], 1);
      got.delete();
      for (int k = 0; k < expq.size(); k++) begin
         tick;
         chk("word_ce_n", ce_n[d], 0);
         chk("word_wr_n", wr_n[d], 0);
         chk($sformatf("word%0d", k), icap[d], rev(expq[k]));
         got.push_back(rev(icap[d]));
         if (k == abort_k) begin
            rst = 1'b1;
            tick;
            chk("abort_ce_n", ce_n[d], 1);
            chk("abort_icap", icap[d], 16'hFFFF);
            chk("abort_busy", busy[d], 0);
            chk("abort_ready", ready[d], 0);
            rst = 1'b0;
            return;
         end
      end
      tick;
      chk("end_ce_n", ce_n[d], 1);
      chk("end_wr_n", wr_n[d], 1);
      chk("end_icap", icap[d], 16'hFFFF);
      chk("end_issued", issued[d], 1);
      chk("end_busy", busy[d], 1);
      chk("end_ready", ready[d], 0);
   endtask

   initial begin
      int n;
      int d;
      int ix;
      rst = 1'b1;
      req = '0;
      idx = '0;
      tick;
      tick;
      tick;
      chk("rst_ready", ready[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_err", err[0], 0);
      chk("rst_issued", issued[0], 0);
      chk("rst_ce_n", ce_n[0], 1);
      chk("rst_wr_n", wr_n[0], 1);
      chk("rst_icap", icap[0], 16'hFFFF);
      chk("rst_ready_all", ready, 3'b000);

      // req held through holdoff; accept on first ready cycle
      req[0] = 1'b1;
      idx[0] = 4'd0;
      rst = 1'b0;
      wait_ready(0, n);
      chk("holdoff_len", n, 15);
      do_req(0, 0, 1'b0, -1);
      chk("i0_size", got.size(), 16);
      chk("i0_sync0", got[0], 16'hAA99);
      chk("i0_sync1", got[1], 16'h5566);
      chk("i0_gen1", got[3], 16'h4000);
      chk("i0_gen2", got[5], 16'h0305);
      chk("i0_gen3", got[7], 16'h0000);
      chk("i0_gen4", got[9], 16'h0300);

      // req held in DONE is ignored
      req[0] = 1'b1;
      repeat (3) tick;
      chk("done_ce_n", ce_n[0], 1);
      chk("done_issued", issued[0], 1);
      chk("done_ready", ready[0], 0);
      chk("done_busy", busy[0], 1);
      req[0] = 1'b0;

      do_reset;
      do_req(0, 4, 1'b0, -1);
      chk("i4_gen1", got[3], 16'h4000);
      chk("i4_gen2", got[5], 16'h031A);

      do_reset;
      do_req(0, 8, 1'b0, -1);
      do_req(0, 3, 1'b1, -1);
      chk("b2b_gen2", got[5], 16'h0315);

      do_reset;
      do_req(1, 1, 1'b0, -1);
      chk("nofb_size", got.size(), 12);
      chk("nofb_gen1", got[3], 16'h8000);
      chk("nofb_gen2", got[5], 16'h030A);
      chk("nofb_w6", got[6], 16'h30A1);
      chk("nofb_w7", got[7], 16'h000E);

      do_reset;
      do_req(2, 1, 1'b0, -1);
      chk("wrap_gen1", got[3], 16'h0000);
      chk("wrap_gen2", got[5], 16'h0301);

      do_reset;
      do_req(0, int'($urandom_range(0, 7)), 1'b0, 5);
      wait_ready(0, n);
      chk("abort_holdoff", n, 15);
      do_req(0, 2, 1'b0, -1);
      chk("i2_size", got.size(), 16);
      chk("i2_gen1", got[3], 16'hC000);
      chk("i2_gen2", got[5], 16'h030F);

      for (int r = 0; r < 12; r++) begin
         do_reset;
         d  = int'($urandom_range(0, 2));
         ix = int'($urandom_range(0, 15));
         do_req(d, ix, 1'b0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
